// File: rtl/bus_pkg.sv
// Shared definitions for the SoC peripheral bus.
// Widths and the initiator state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 12;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } bus_init_state_t;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding peripheral bus master with
// ack timeout and saturating error counter.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              sel_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              ack_i,
  output logic [7:0]        err_count_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT - 1);

  bus_init_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             ack_hit;
  logic             tmo;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    tmo         = 1'b0;
    req_ready_o = (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // ack on the final count still wins
        if (ack_i) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end else if (cnt_q == LAST) begin
          tmo     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_o       <= 1'b0;
      wr_en_o     <= 1'b0;
      address_o   <= '0;
      data_o      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= '0;
      err_count_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_o       <= accept;
      rsp_valid_o <= (state_d == RESP);
      if (accept) begin
        wr_en_o   <= req_wr_i;
        address_o <= req_addr_i;
        data_o    <= req_data_i;
      end
      if (ack_hit) begin
        rsp_data_o <= wr_en_o ? '0 : data_in_i;
        rsp_err_o  <= 1'b0;
      end else if (tmo) begin
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
        if (err_count_o != 8'hFF)
          err_count_o <= err_count_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed and randomized checks of bus_initiator
// against a cycle-level transaction model.
module tb_bus_initiator;

  localparam int TO = 16;

  logic        clk;
  logic        reset_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        sel_o;
  logic        wr_en_o;
  logic [11:0] address_o;
  logic [31:0] data_o;
  logic [31:0] data_in_i;
  logic        ack_i;
  logic [7:0]  err_count_o;

  int tests = 0;
  int fails = 0;
  int errs  = 0;

  logic [31:0] ref_mem [4096];
  logic [31:0] dev_mem [4096];

  bus_initiator #(
    .ADDR_W (12),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_wr_i   (req_wr_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .sel_o      (sel_o),
    .wr_en_o    (wr_en_o),
    .address_o  (address_o),
    .data_o     (data_o),
    .data_in_i  (data_in_i),
    .ack_i      (ack_i),
    .err_count_o(err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"}, 32'(sel_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_addr"}, 32'(address_o), 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data_o, 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_count_o), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  // a = spec cycle (accept edge = cycle 0) in which
  // the device pulses ack; hold = cycles rsp_ready
  // stays low once the response is up.
  task automatic txn(input bit wr,
                     input logic [11:0] addr,
                     input logic [31:0] data,
                     input int a,
                     input int hold);
    int er;
    int cyc;
    bit xerr;
    bit done;
    bit last;
    logic [31:0] xdata;
    xerr  = !(a >= 2 && a <= TO + 1);
    er    = xerr ? TO + 2 : a + 1;
    xdata = (xerr || wr) ? 32'd0 : ref_mem[addr];
    if (wr) ref_mem[addr] = data;
    if (xerr && errs < 255) errs++;
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_addr_i  = addr;
    req_data_i  = data;
    rsp_ready_i = 1'b0;
    ack_i       = 1'b0;
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    step();
    req_valid_i = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 80) begin
      chk("sel", 32'(sel_o), 32'(cyc == 1));
      if (cyc == 1) begin
        chk("wr_en", 32'(wr_en_o), 32'(wr));
        chk("address", 32'(address_o), 32'(addr));
        chk("data_out", data_o, data);
      end
      if (sel_o && wr_en_o)
        dev_mem[address_o] = data_o;
      chk("req_ready_busy", 32'(req_ready_o), 32'd0);
      chk("rsp_valid", 32'(rsp_valid_o), 32'(cyc >= er));
      if (cyc >= er) begin
        chk("rsp_data", rsp_data_o, xdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(xerr));
        chk("err_count", 32'(err_count_o), 32'(errs));
      end
      req_valid_i = 1'($urandom % 2);
      req_wr_i    = 1'($urandom % 2);
      req_addr_i  = 12'($urandom);
      req_data_i  = $urandom;
      ack_i = (cyc == a) ||
              (cyc >= er && ($urandom % 2 == 1));
      data_in_i = ack_i ? dev_mem[address_o]
                        : $urandom;
      last = (cyc >= er + hold);
      rsp_ready_i = last ? 1'b1 :
                    (cyc < er) ? 1'($urandom % 2)
                               : 1'b0;
      step();
      cyc++;
      if (last) done = 1'b1;
    end
    chk("bound", 32'(done), 32'd1);
    req_valid_i = 1'b0;
    ack_i       = 1'b0;
    rsp_ready_i = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
    chk("req_ready_back", 32'(req_ready_o), 32'd1);
    chk("sel_idle", 32'(sel_o), 32'd0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 32'd0;
      dev_mem[i] = 32'd0;
    end
    reset_n_i   = 1'b0;
    req_valid_i = 1'b0;
    req_wr_i    = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b0;
    data_in_i   = '0;
    ack_i       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n_i = 1'b1;
    step();

    // LED-style write then read back
    txn(1'b1, 12'h000, 32'h0000_00A5, 2, 0);
    txn(1'b0, 12'h000, 32'h0, 2, 0);
    // never acks
    txn(1'b0, 12'h001, 32'h0, 1000, 0);
    // ack on final WAIT cycle
    txn(1'b0, 12'h000, 32'h0, TO + 1, 1);
    // ack one cycle too late
    txn(1'b0, 12'h000, 32'h0, TO + 2, 3);
    // response held off for 5 cycles
    txn(1'b1, 12'h003, 32'hDEAD_BEEF, 3, 5);
    txn(1'b0, 12'h003, 32'h0, 4, 5);
    // ack during the strobe cycle
    txn(1'b0, 12'h003, 32'h0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 1000
          : int'($urandom_range(1, TO + 4));
      txn(1'($urandom % 2),
          12'($urandom_range(0, 7)),
          $urandom, a,
          int'($urandom_range(0, 3)));
    end

    // reset in the middle of WAIT
    req_valid_i = 1'b1;
    req_wr_i    = 1'b0;
    req_addr_i  = 12'h005;
    step();
    req_valid_i = 1'b0;
    repeat (4) step();
    reset_n_i = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    errs = 0;
    step();
    reset_n_i = 1'b1;
    step();
    chk("no_rsp_after_reset", 32'(rsp_valid_o), 32'd0);
    txn(1'b0, 12'h005, 32'h0, 2, 1);
    txn(1'b1, 12'h006, 32'h1234_5678, 2, 0);
    txn(1'b0, 12'h006, 32'h0, 5, 0);

    // drive the error counter into saturation
    for (int n = 0; n < 258; n++)
      txn(1'b0, 12'h007, 32'h0, 1000, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
